iram_dp_ctrl: RTL and testbench
===============================

Name: iram_dp_ctrl

Overview:
Parametrised successor to the 8051 internal data RAM. Two independent write channels (core and SFR/DMA side) and one registered read port, all on one clock. A hardware clear sequencer loads INIT_VAL into every location after reset. Defined collision and read-after-write bypass rules replace the old level-sensitive write behaviour. Sits between the DW8051 core memory bus and the I2C master data path.

Parameters:
DATA_W, 8, word width in bits
ADDR_W, 8, address width in bits
DEPTH, 256, number of words; must be ≤ 2**ADDR_W
INIT_VAL, 0, word value written to every location by the clear sequencer

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
addr_a  in  ADDR_W  write channel A address
wdata_a  in  DATA_W  write channel A data
we1_n  in  1  write enable A, active low
addr_b  in  ADDR_W  write channel B address
wdata_b  in  DATA_W  write channel B data
we2_n  in  1  write enable B, active low
raddr  in  ADDR_W  read address
rd_n  in  1  read strobe, active low
data_out  out  DATA_W  registered read data
rd_valid  out  1  data_out holds the result of the previous cycle's read
init_busy  out  1  clear sequencer running; accesses ignored
wr_collide  out  1  one-cycle pulse: A and B wrote the same address in the same cycle
par_err  out  1  parity error pulse; see Optional Feature

Behaviour:
- Reset values (rst_n low, async): data_out=0, rd_valid=0, init_busy=1, wr_collide=0, par_err=0, FSM=CLEAR, clear counter=0.
- FSM states: CLEAR, READY.
- CLEAR state:
  - Each cycle writes INIT_VAL to mem[cnt], then cnt += 1.
  - When cnt == DEPTH-1 is written, next state is READY and init_busy falls on that edge.
  - Duration is exactly DEPTH cycles after rst_n rises.
- While init_busy=1: we1_n, we2_n and rd_n are ignored; rd_valid stays 0.
- READY state: stays in READY until rst_n is asserted.
- Reset asserted mid-CLEAR or mid-READY: FSM returns to CLEAR immediately; the full clear restarts after release.
- Writes (READY only): mem[addr] <= wdata on the rising edge when the enable is low.
  - A and B to different addresses in the same cycle: both take effect.
  - A and B to the same address in the same cycle: A wins; wr_collide=1 for the following cycle only.
- Out-of-range addresses (addr ≥ DEPTH): writes are dropped; reads return INIT_VAL with rd_valid=1.
- Reads:
  - rd_n low at edge N gives data_out and rd_valid=1 during cycle N+1 (latency 1).
  - rd_n high at an edge gives rd_valid=0 and data_out holds its previous value.
- Read-after-write bypass (write-first):
  - If raddr matches a write address in the same cycle, data_out returns the new data.
  - Priority when both writes hit raddr: A, then B, then array contents.
- Back-to-back reads: one per cycle, no bubbles.

Optional Feature:
Macro IRAM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed on write (and on clear).
  - On every valid read, parity is recomputed over the stored data.
  - A mismatch makes par_err=1 in the same cycle as rd_valid.
  - Bypassed reads never flag.
  - A sim-only task flip_bit(addr, bit) corrupts stored data for test.
- Undefined: no parity storage; par_err tied to 0.

Decomposition:
- Package iram_pkg holds:
  - FSM state enum {CLEAR, READY}
  - DATA_W/ADDR_W defaults
  - parity function
- One sub-module, iram_clear_seq: owns the CLEAR/READY FSM and counter; outputs clr_we, clr_addr, init_busy.
- Top level contains the array, write arbitration, bypass mux and read register.

Test Plan:
- Clear: release rst_n with DEPTH=256, INIT_VAL=8'hA5 -> init_busy high for exactly 256 cycles; then reads of 0x00, 0x7F and 0xFF return 8'hA5 with rd_valid=1 one cycle after each rd_n.
- Dual write: same cycle A writes 0x10<=0x3C, B writes 0x20<=0xC3 -> later reads return 0x3C and 0xC3; wr_collide stays 0.
- Collision: same cycle A writes 0x40<=0x11, B writes 0x40<=0x22 -> wr_collide=1 for one cycle; read of 0x40 returns 0x11.
- Bypass: in one cycle, B writes 0x55<=0x9E and rd_n is low with raddr=0x55 -> next cycle data_out=0x9E, rd_valid=1.
- Reset mid-clear: assert rst_n at clear cycle 100, release, write 0x05<=0x77 during init_busy -> write ignored; full 256-cycle clear repeats; read of 0x05 returns INIT_VAL.
- Parity (IRAM_PARITY_EN): write 0x30<=0x0F, flip bit 0, read 0x30 -> data_out=0x0E, par_err=1 with rd_valid; unflipped read of 0x31 gives par_err=0.

Source files
------------

// File: rtl/iram_pkg.sv
// Shared types and helpers for the dual-write internal data RAM.
package iram_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned ADDR_W_DEF = 8;

   typedef enum logic {CLEAR, READY} iram_state_e;

   // Even parity bit; zero-extension does not change parity, so any word up to 64 bits fits
   function automatic logic parity64(input logic [63:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/iram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, then holds READY until the next reset.
module iram_clear_seq
   import iram_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              init_busy
);

   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

   iram_state_e       state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastAddr) state_d = READY;
         end
         READY: ;
         default: state_d = CLEAR;
      endcase
   end

   assign clr_we    = (state_q == CLEAR);
   assign clr_addr  = cnt_q;
   assign init_busy = (state_q == CLEAR);

endmodule

// File: rtl/iram_dp_ctrl.sv
// Dual-write, single registered-read internal RAM with hardware clear and write-first bypass.
// Optional even-parity storage and checking enabled by defining IRAM_PARITY_EN.
module iram_dp_ctrl
   import iram_pkg::*;
#(
   parameter int unsigned       DATA_W   = DATA_W_DEF,
   parameter int unsigned       ADDR_W   = ADDR_W_DEF,
   parameter int unsigned       DEPTH    = 256,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [DATA_W-1:0] wdata_a,
   input  logic              we1_n,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] wdata_b,
   input  logic              we2_n,
   input  logic [ADDR_W-1:0] raddr,
   input  logic              rd_n,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid,
   output logic              init_busy,
   output logic              wr_collide,
   output logic              par_err
);

   localparam logic [ADDR_W:0] DepthL = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;

   logic              a_ok, b_ok, r_ok;
   logic              we_a, we_b, we_b_win;
   logic              hit_a, hit_b;
   logic [DATA_W-1:0] rdata;
   logic              par_bad;

   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              rd_valid_q, rd_valid_d;
   logic              wr_collide_q, wr_collide_d;
   logic              par_err_q, par_err_d;

   iram_clear_seq #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_clear_seq (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_we    (clr_we),
      .clr_addr  (clr_addr),
      .init_busy (init_busy)
   );

   assign a_ok = ({1'b0, addr_a} < DepthL);
   assign b_ok = ({1'b0, addr_b} < DepthL);
   assign r_ok = ({1'b0, raddr}  < DepthL);

   assign we_a     = !we1_n && !init_busy && a_ok;
   assign we_b     = !we2_n && !init_busy && b_ok;
   // On a same-address collision only channel A reaches the array
   assign we_b_win = we_b && !(we_a && (addr_a == addr_b));

   assign hit_a = we_a && (addr_a == raddr);
   assign hit_b = we_b && (addr_b == raddr);

   always_comb begin
      rdata = mem[raddr];
      if (!r_ok)      rdata = INIT_VAL;
      else if (hit_a) rdata = wdata_a;
      else if (hit_b) rdata = wdata_b;
   end

`ifdef IRAM_PARITY_EN
   logic par_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (clr_we) begin
         par_mem[clr_addr] <= parity64(64'(INIT_VAL));
      end else begin
         if (we_b_win) par_mem[addr_b] <= parity64(64'(wdata_b));
         if (we_a)     par_mem[addr_a] <= parity64(64'(wdata_a));
      end
   end

   assign par_bad = r_ok && !hit_a && !hit_b &&
                    (parity64(64'(mem[raddr])) != par_mem[raddr]);

   // Simulation aid: corrupt one stored data bit without touching its parity
   task automatic flip_bit(input int unsigned addr, input int unsigned bit_idx);
      mem[addr][bit_idx] <= ~mem[addr][bit_idx];
   endtask
`else
   assign par_bad = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= INIT_VAL;
      end else begin
         if (we_b_win) mem[addr_b] <= wdata_b;
         if (we_a)     mem[addr_a] <= wdata_a;
      end
   end

   always_comb begin
      rd_valid_d   = !rd_n && !init_busy;
      data_out_d   = rd_valid_d ? rdata : data_out_q;
      wr_collide_d = we_a && we_b && (addr_a == addr_b);
      par_err_d    = rd_valid_d && par_bad;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out_q   <= '0;
         rd_valid_q   <= 1'b0;
         wr_collide_q <= 1'b0;
         par_err_q    <= 1'b0;
      end else begin
         data_out_q   <= data_out_d;
         rd_valid_q   <= rd_valid_d;
         wr_collide_q <= wr_collide_d;
         par_err_q    <= par_err_d;
      end
   end

   assign data_out   = data_out_q;
   assign rd_valid   = rd_valid_q;
   assign wr_collide = wr_collide_q;
   assign par_err    = par_err_q;

endmodule

// File: tb/tb_iram_dp_ctrl.sv
// Scoreboard bench for iram_dp_ctrl: per-cycle expectations from a behavioural model, popped by a monitor.
module tb_iram_dp_ctrl;

   localparam int          DEPTH = 256;
   localparam logic [7:0]  INIT  = 8'hA5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] addr_a = '0, wdata_a = '0, addr_b = '0, wdata_b = '0, raddr = '0;
   logic       we1_n = 1'b1, we2_n = 1'b1, rd_n = 1'b1;
   logic [7:0] data_out;
   logic       rd_valid, init_busy, wr_collide, par_err;

   iram_dp_ctrl #(
      .DATA_W   (8),
      .ADDR_W   (8),
      .DEPTH    (DEPTH),
      .INIT_VAL (INIT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .addr_a     (addr_a),
      .wdata_a    (wdata_a),
      .we1_n      (we1_n),
      .addr_b     (addr_b),
      .wdata_b    (wdata_b),
      .we2_n      (we2_n),
      .raddr      (raddr),
      .rd_n       (rd_n),
      .data_out   (data_out),
      .rd_valid   (rd_valid),
      .init_busy  (init_busy),
      .wr_collide (wr_collide),
      .par_err    (par_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         valid;
      logic [7:0] data;
      bit         busy;
      bit         coll;
      bit         perr;
   } rec_t;

   rec_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state
   logic [7:0] mm [DEPTH];
   bit         corrupt [DEPTH];
   logic [7:0] mdout = '0;
   int         rel = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
      end
   endtask

   initial begin
      rec_t r;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            chk("rd_valid", 32'(rd_valid), 32'(r.valid));
            chk("data_out", 32'(data_out), 32'(r.data));
            chk("init_busy", 32'(init_busy), 32'(r.busy));
            chk("wr_collide", 32'(wr_collide), 32'(r.coll));
            chk("par_err", 32'(par_err), 32'(r.perr));
         end
      end
   end

   task automatic step(input bit w1n, input logic [7:0] a, input logic [7:0] wa,
                       input bit w2n, input logic [7:0] b, input logic [7:0] wb,
                       input bit rdn, input logic [7:0] ra);
      rec_t r;
      we1_n = w1n; addr_a = a; wdata_a = wa;
      we2_n = w2n; addr_b = b; wdata_b = wb;
      rd_n  = rdn; raddr = ra;
      @(posedge clk);
      r.valid = 0; r.coll = 0; r.perr = 0;
      if (rel < DEPTH) begin
         rel++;
         if (rel == DEPTH) begin
            for (int i = 0; i < DEPTH; i++) begin
               mm[i] = INIT;
               corrupt[i] = 0;
            end
         end
      end else begin
         r.coll = !w1n && !w2n && (a == b);
         if (!rdn) begin
            r.valid = 1;
            if (!w1n && a == ra)      mdout = wa;
            else if (!w2n && b == ra) mdout = wb;
            else begin
               mdout  = mm[ra];
               r.perr = corrupt[ra];
            end
         end
         if (!w2n) begin mm[b] = wb; corrupt[b] = 0; end
         if (!w1n) begin mm[a] = wa; corrupt[a] = 0; end
      end
      r.busy = (rel < DEPTH);
      r.data = mdout;
      exp_q.push_back(r);
      #2;
   endtask

   task automatic idle();
      step(1, 8'h00, 8'h00, 1, 8'h00, 8'h00, 1, 8'h00);
   endtask

   task automatic rd(input logic [7:0] ra);
      step(1, 8'h00, 8'h00, 1, 8'h00, 8'h00, 0, ra);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst data_out", 32'(data_out), 32'h0);
      chk("rst rd_valid", 32'(rd_valid), 32'h0);
      chk("rst init_busy", 32'(init_busy), 32'h1);
      chk("rst wr_collide", 32'(wr_collide), 32'h0);
      chk("rst par_err", 32'(par_err), 32'h0);
      mdout = '0;
      rel   = 0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   function automatic logic [7:0] rnd_addr();
      if ($urandom_range(0, 1) == 0) return 8'($urandom_range(0, 7));
      return 8'($urandom_range(0, 255));
   endfunction

   initial begin
      do_reset();
      // Clear phase with accesses that must be ignored
      for (int i = 0; i < DEPTH; i++) begin
         if (i % 37 == 3) step(0, 8'h05, 8'h77, 0, 8'h06, 8'h12, 0, 8'h05);
         else idle();
      end
      rd(8'h00); rd(8'h7F); rd(8'hFF); rd(8'h05);
      idle();

      step(0, 8'h10, 8'h3C, 0, 8'h20, 8'hC3, 1, 8'h00);
      rd(8'h10); rd(8'h20);
      step(0, 8'h40, 8'h11, 0, 8'h40, 8'h22, 1, 8'h00);
      idle();
      rd(8'h40);
      step(1, 8'h00, 8'h00, 0, 8'h55, 8'h9E, 0, 8'h55);
      step(0, 8'h66, 8'h01, 0, 8'h66, 8'h02, 0, 8'h66);
      step(1, 8'h00, 8'h00, 0, 8'h67, 8'h44, 0, 8'h67);
      rd(8'h55); rd(8'h66); rd(8'h67);

      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), rnd_addr(), 8'($urandom),
              1'($urandom_range(0, 1)), rnd_addr(), 8'($urandom),
              1'($urandom_range(0, 3) == 0), rnd_addr());
      end

      // Reset mid-clear, then restart with a write attempted during busy
      do_reset();
      for (int i = 0; i < 100; i++) begin
         if (i == 50) step(0, 8'h05, 8'h77, 1, 8'h00, 8'h00, 1, 8'h00);
         else idle();
      end
      do_reset();
      step(0, 8'h05, 8'h77, 1, 8'h00, 8'h00, 0, 8'h05);
      for (int i = 1; i < DEPTH; i++) idle();
      rd(8'h05);
      rd(8'h10);

`ifdef IRAM_PARITY_EN
      step(0, 8'h30, 8'h0F, 0, 8'h31, 8'h5A, 1, 8'h00);
      dut.flip_bit(32'h30, 32'h0);
      mm[8'h30][0] = ~mm[8'h30][0];
      corrupt[8'h30] = 1;
      rd(8'h30);
      rd(8'h31);
      step(1, 8'h00, 8'h00, 0, 8'h30, 8'h0E, 0, 8'h30);
      rd(8'h30);
`endif

      idle();
      @(negedge clk);
      #1;
      chk("queue drained", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
